// File: rtl/ddr_cntrl_pkg.sv
// Shared widths and FSM encoding for the behavioural DDR controller.
package ddr_pkg;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 4;
    localparam int LANES   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } ddr_state_e;
endpackage

// File: rtl/ddr_cntrl_mem_array.sv
// Word-organised byte-lane storage: one strobed write port and one word read port
// whose output register resets to zero and holds between reads.
module ddr_mem_array
    import ddr_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int WA    = $clog2(WORDS)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              i_we,
    input  logic [WA-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [LANES-1:0]  i_wstrb,
    input  logic              i_re,
    input  logic [WA-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] r_mem [0:WORDS-1];
            logic [7:0] r_rd;

            always_ff @(posedge aclk) begin
                if (i_we && i_wstrb[gi]) begin
                    r_mem[i_waddr] <= i_wdata[8*gi +: 8];
                end
            end

            // Storage itself is never cleared; only the read register is.
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    r_rd <= '0;
                end else if (i_re) begin
                    r_rd <= r_mem[i_raddr];
                end
            end

            assign o_rdata[8*gi +: 8] = r_rd;
        end
    endgenerate
endmodule

// File: rtl/ddr_cntrl.sv
// Burst DDR controller front: command snapshot/start detect, burst FSM and
// word address generation in front of the byte-lane memory array.
module ddr_cntrl
    import ddr_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [ADDR_W-1:0]  logical_addr,
    input  logic [DATA_W-1:0]  pwdata,
    input  logic               pwrite,
    output logic [DATA_W-1:0]  prdata,
    input  logic [LANES-1:0]   strobe,
    input  logic [BURST_W-1:0] burstlen
);
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WA    = AW - 2;
    localparam int WORDS = MEM_BYTES / LANES;

    ddr_state_e         r_state;
    logic [BURST_W-1:0] r_cnt;
    logic [BURST_W-1:0] r_len;
    logic [WA-1:0]      r_base;
    logic [ADDR_W-1:0]  r_snap_addr;
    logic               r_snap_wr;

    logic          w_start;
    logic [WA-1:0] w_in_word;
    logic [WA-1:0] w_beat_word;
    logic [WA-1:0] w_word;
    logic          w_we;
    logic          w_re;
    logic [DATA_W-1:0] w_rdata;

    assign w_start     = (r_state == IDLE) &&
                         ({logical_addr, pwrite} != {r_snap_addr, r_snap_wr});
    // Dropping the low address bits aligns to a word; dropping the high bits wraps.
    assign w_in_word   = logical_addr[AW-1:2];
    assign w_beat_word = r_base + WA'(r_cnt);
    assign w_word      = (r_state == IDLE) ? w_in_word : w_beat_word;
    assign w_we        = aresetn && ((w_start && pwrite) || (r_state == WRITE));
    assign w_re        = aresetn && ((w_start && !pwrite) || (r_state == READ));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_base      <= '0;
            r_snap_addr <= '1;
            r_snap_wr   <= 1'b0;
        end else begin
            r_snap_addr <= logical_addr;
            r_snap_wr   <= pwrite;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_base <= w_in_word;
                        r_len  <= burstlen;
                        // Beat 0 is served in the start cycle itself.
                        if (burstlen != '0) begin
                            r_cnt   <= BURST_W'(1);
                            r_state <= pwrite ? WRITE : READ;
                        end
                    end
                end
                WRITE, READ: begin
                    if (r_cnt == r_len) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + BURST_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ddr_mem_array #(
        .WORDS (WORDS),
        .WA    (WA)
    ) u_mem (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_we    (w_we),
        .i_waddr (w_word),
        .i_wdata (pwdata),
        .i_wstrb (strobe),
        .i_re    (w_re),
        .i_raddr (w_word),
        .o_rdata (w_rdata)
    );

    assign prdata = w_rdata;
endmodule

// File: tb/tb_ddr_cntrl.sv
// Bench for ddr_cntrl: byte-array reference model checked every cycle, plus
// directed literal expectations and randomized bursts.
module tb_ddr_cntrl;
    localparam int MEM_BYTES = 1024;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] logical_addr = 32'hFFFF_FFFF;
    logic [31:0] pwdata = 32'h0;
    logic        pwrite = 1'b0;
    logic [31:0] prdata;
    logic [3:0]  strobe = 4'h0;
    logic [3:0]  burstlen = 4'h0;

    ddr_cntrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .logical_addr (logical_addr),
        .pwdata       (pwdata),
        .pwrite       (pwrite),
        .prdata       (prdata),
        .strobe       (strobe),
        .burstlen     (burstlen)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: a byte array plus "beats still to do" bookkeeping.
    logic [7:0]  m_mem [0:MEM_BYTES-1];
    bit          m_busy = 1'b0;
    bit          m_wr = 1'b0;
    int          m_base = 0;
    int          m_len = 0;
    int          m_k = 0;
    logic [31:0] m_prd = 32'h0;
    logic [32:0] m_snap = {32'hFFFF_FFFF, 1'b0};

    function automatic void m_beat(input int k);
        int a;
        a = (m_base + 4 * k) % MEM_BYTES;
        if (m_wr) begin
            for (int i = 0; i < 4; i++)
                if (strobe[i]) m_mem[a + i] = pwdata[8*i +: 8];
        end else begin
            m_prd = {m_mem[a + 3], m_mem[a + 2], m_mem[a + 1], m_mem[a]};
        end
    endfunction

    always @(posedge aclk) begin
        if (!aresetn) begin
            m_busy = 1'b0;
            m_prd  = 32'h0;
            m_snap = {32'hFFFF_FFFF, 1'b0};
        end else begin
            if (!m_busy) begin
                if ({logical_addr, pwrite} !== m_snap) begin
                    m_base = int'(logical_addr % 32'(MEM_BYTES)) & ~3;
                    m_len  = int'(burstlen);
                    m_wr   = pwrite;
                    m_beat(0);
                    if (m_len > 0) begin
                        m_busy = 1'b1;
                        m_k    = 1;
                    end
                end
            end else begin
                m_beat(m_k);
                if (m_k == m_len) m_busy = 1'b0;
                else m_k++;
            end
            m_snap = {logical_addr, pwrite};
        end
        #1;
        chk("prdata_model", prdata, m_prd);
    end

    logic [31:0] rd_got [0:15];

    // Issue one burst starting at a negedge; ends at the negedge after its last beat.
    // rd_got[k] holds prdata one cycle after beat k.
    task automatic run_cmd(input logic [31:0] addr, input logic wr, input int len,
                           input logic [31:0] d0, input logic [31:0] step,
                           input logic [3:0] stb, input bit rnd);
        logical_addr = addr;
        pwrite       = wr;
        burstlen     = 4'(len);
        pwdata       = rnd ? $urandom : d0;
        strobe       = rnd ? 4'($urandom) : stb;
        for (int k = 0; k <= len; k++) begin
            @(posedge aclk);
            #1;
            rd_got[k] = prdata;
            @(negedge aclk);
            if (k < len) begin
                pwdata = rnd ? $urandom : d0 + 32'(k + 1) * step;
                strobe = rnd ? 4'($urandom) : stb;
                if (rnd) begin
                    logical_addr = $urandom;
                    pwrite       = 1'($urandom_range(0, 1));
                    burstlen     = 4'($urandom);
                end else if (k + 1 == len) begin
                    // Ignored mid-burst; lets the next command reuse the same fields.
                    logical_addr = addr ^ 32'h8000_0000;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge aclk);
        @(posedge aclk);
        #1;
        chk("reset_prdata", prdata, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        chk("idle_after_reset_prdata", prdata, 32'h0);

        // Fill the whole store with a known address pattern.
        for (int b = 0; b < MEM_BYTES; b += 64)
            run_cmd(32'(b), 1'b1, 15, 32'h5A00_0000 + 32'(b), 32'd4, 4'hF, 1'b0);

        run_cmd(32'h10, 1'b1, 0, 32'hDEAD_BEEF, 32'h0, 4'hF, 1'b0);
        run_cmd(32'h10, 1'b0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("single_read", rd_got[0], 32'hDEAD_BEEF);

        run_cmd(32'h20, 1'b1, 3, 32'h1111_1111, 32'h1111_1111, 4'hF, 1'b0);
        chk("prdata_hold", prdata, 32'hDEAD_BEEF);
        run_cmd(32'h20, 1'b0, 3, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("burst_beat0", rd_got[0], 32'h1111_1111);
        chk("burst_beat1", rd_got[1], 32'h2222_2222);
        chk("burst_beat2", rd_got[2], 32'h3333_3333);
        chk("burst_beat3", rd_got[3], 32'h4444_4444);

        run_cmd(32'h20, 1'b1, 1, 32'hAABB_CCDD, 32'h0, 4'hF, 1'b0);
        run_cmd(32'h20, 1'b1, 0, 32'h1234_5678, 32'h0, 4'b0101, 1'b0);
        run_cmd(32'h20, 1'b0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("partial_strobe", rd_got[0], 32'hAA34_CC78);

        run_cmd(32'h23, 1'b1, 0, 32'hCAFE_F00D, 32'h0, 4'hF, 1'b0);
        run_cmd(32'h21, 1'b0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("unaligned", rd_got[0], 32'hCAFE_F00D);

        run_cmd(32'(MEM_BYTES - 4), 1'b1, 1, 32'h0A0A_0A0A, 32'h0101_0101, 4'hF, 1'b0);
        run_cmd(32'h0, 1'b0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("wrap_read0", rd_got[0], 32'h0B0B_0B0B);
        run_cmd(32'(MEM_BYTES - 4), 1'b0, 1, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("wrap_beat0", rd_got[0], 32'h0A0A_0A0A);
        chk("wrap_beat1", rd_got[1], 32'h0B0B_0B0B);

        // Reset after beat 1 of a 4-beat write.
        logical_addr = 32'h40;
        pwrite       = 1'b1;
        burstlen     = 4'd3;
        pwdata       = 32'h0101_0101;
        strobe       = 4'hF;
        @(negedge aclk);
        pwdata = 32'h0202_0202;
        @(negedge aclk);
        aresetn = 1'b0;
        pwrite  = 1'b0;
        @(posedge aclk);
        #1;
        chk("abort_prdata", prdata, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        run_cmd(32'h40, 1'b0, 3, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("abort_word0", rd_got[0], 32'h0101_0101);
        chk("abort_word1", rd_got[1], 32'h0202_0202);
        chk("abort_word2", rd_got[2], 32'h5A00_0048);
        chk("abort_word3", rd_got[3], 32'h5A00_004C);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            logic        w;
            a = $urandom;
            w = 1'($urandom_range(0, 1));
            if ({a, w} == {logical_addr, pwrite}) a = a ^ 32'h1;
            run_cmd(a, w, $urandom_range(0, 15), 32'h0, 32'h0, 4'h0, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge aclk);
        end

        repeat (2) @(negedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
